// File: rtl/nios_system_sysid_pkg.sv
// nios_system_sysid_pkg: shared types and constants for the sysid checker.
// State encoding, slave word addresses and default image constants.
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    BACKOFF,
    CHECK,
    DONE
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEF_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEF_TS = 32'd1581593513;

endpackage

// File: rtl/nios_system_sysid_wdog.sv
// nios_system_sysid_wdog: per-read stall counter for the sysid checker.
// Saturates at TIMEOUT_CYCLES so it never wraps.
module nios_system_sysid_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker: reads sysid ID/timestamp and compares them.
// Timestamp read and compare compiled in only with SYSID_CHECK_TS_EN.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEF_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEF_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

`ifdef SYSID_CHECK_TS_EN
  localparam state_e AFTER_ID = RD_TS;
`else
  localparam state_e AFTER_ID = CHECK;
`endif

  state_e      state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic        id_ok_q, id_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] read_id_q, read_id_d;
`ifdef SYSID_CHECK_TS_EN
  logic        ts_ok_q, ts_ok_d;
  logic [31:0] read_ts_q, read_ts_d;
`endif

  logic accept, stall, expired, give_up, wd_clear, abandon;

  assign accept   = avm_read & ~avm_waitrequest;
  assign stall    = avm_read & avm_waitrequest;
  assign abandon  = stall & expired;
  assign give_up  = (retry_q == MAX_R);
  assign wd_clear = accept | (state_d != state_q);

  nios_system_sysid_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (wd_clear),
    .count_en (stall),
    .expired  (expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RD_ID;
      RD_ID: begin
        if (accept) state_d = AFTER_ID;
        else if (abandon) state_d = give_up ? DONE : BACKOFF;
      end
`ifdef SYSID_CHECK_TS_EN
      RD_TS: begin
        if (accept) state_d = CHECK;
        else if (abandon) state_d = give_up ? DONE : BACKOFF;
      end
`endif
      BACKOFF: state_d = RD_ID;
      CHECK:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    avm_read    = 1'b0;
    avm_address = SYSID_ADDR_ID;
    unique case (state_q)
      RD_ID: avm_read = 1'b1;
`ifdef SYSID_CHECK_TS_EN
      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = SYSID_ADDR_TS;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_comb begin
    retry_d   = retry_q;
    id_ok_d   = id_ok_q;
    timeout_d = timeout_q;
    read_id_d = read_id_q;
`ifdef SYSID_CHECK_TS_EN
    ts_ok_d   = ts_ok_q;
    read_ts_d = read_ts_q;
    if (state_q == RD_TS && accept) read_ts_d = avm_readdata;
`endif
    if (state_q == IDLE && start) begin
      retry_d   = '0;
      id_ok_d   = 1'b0;
      timeout_d = 1'b0;
`ifdef SYSID_CHECK_TS_EN
      ts_ok_d   = 1'b0;
`endif
    end
    if (state_q == RD_ID && accept) read_id_d = avm_readdata;
    if (abandon) begin
      if (give_up) timeout_d = 1'b1;
      else retry_d = retry_q + 4'd1;
    end
    if (state_q == CHECK) begin
      id_ok_d = (read_id_q == EXPECTED_ID);
`ifdef SYSID_CHECK_TS_EN
      ts_ok_d = (read_ts_q == EXPECTED_TS);
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      retry_q   <= '0;
      id_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      read_id_q <= '0;
`ifdef SYSID_CHECK_TS_EN
      ts_ok_q   <= 1'b0;
      read_ts_q <= '0;
`endif
    end else begin
      retry_q   <= retry_d;
      id_ok_q   <= id_ok_d;
      timeout_q <= timeout_d;
      read_id_q <= read_id_d;
`ifdef SYSID_CHECK_TS_EN
      ts_ok_q   <= ts_ok_d;
      read_ts_q <= read_ts_d;
`endif
    end
  end

  assign id_ok   = id_ok_q;
  assign timeout = timeout_q;
  assign read_id = read_id_q;
`ifdef SYSID_CHECK_TS_EN
  assign ts_ok   = ts_ok_q;
  assign read_ts = read_ts_q;
`else
  // Timestamp check is compiled out; constant kept only for a uniform interface.
  logic unused_ts;
  assign unused_ts = ^EXPECTED_TS;
  assign ts_ok   = 1'b1;
  assign read_ts = '0;
`endif

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// tb_nios_system_sysid_checker: scoreboard bench with a behavioural slave.
// Adapts expectations to SYSID_CHECK_TS_EN.
module tb_nios_system_sysid_checker;

  localparam int T = 4;
  localparam int R = 1;
  localparam logic [31:0] EID = 32'h0000_0000;
  localparam logic [31:0] ETS = 32'd1581593513;
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef struct {
    int          cyc;
    int          c0;
    bit          id_ok;
    bit          ts_ok;
    bit          to;
    logic [31:0] rid;
    logic [31:0] rts;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] read_id, read_ts;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t q[$];
  logic [31:0] m_rid = '0;
  logic [31:0] m_rts = '0;

  int sid, sts;
  logic [31:0] vid, vts;
  bit rd_act = 1'b0;
  int left = 0;

  nios_system_sysid_checker #(
    .EXPECTED_ID    (EID),
    .EXPECTED_TS    (ETS),
    .TIMEOUT_CYCLES (T),
    .MAX_RETRIES    (R)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .read_id         (read_id),
    .read_ts         (read_ts)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Slave: stalls each new read by a per-address count, then returns data.
  always @(negedge clock) begin
    if (!avm_read) begin
      rd_act = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      if (!rd_act) begin
        rd_act = 1'b1;
        left = avm_address ? sts : sid;
      end
      if (left > 0) begin
        avm_waitrequest = 1'b1;
        left--;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata = avm_address ? vts : vid;
        rd_act = 1'b0;
      end
    end
  end

  // Reference: attempt-level walk; a read succeeds if its stall <= T.
  function automatic exp_t model(int si, int st, logic [31:0] vi,
                                 logic [31:0] vt);
    exp_t e;
    int c;
    bit ok;
    c = 0;
    ok = 1'b0;
    e.rid = m_rid;
    e.rts = m_rts;
    e.to = 1'b0;
    e.id_ok = 1'b0;
    e.ts_ok = !TS_EN;
    e.c0 = 0;
    for (int a = 0; a <= R && !ok; a++) begin
      if (si > T) begin
        c += T + 1;
      end else begin
        c += si + 1;
        e.rid = vi;
        if (!TS_EN) ok = 1'b1;
        else if (st > T) c += T + 1;
        else begin
          c += st + 1;
          e.rts = vt;
          ok = 1'b1;
        end
      end
      if (!ok && a < R) c += 1;
    end
    if (ok) begin
      c += 2;
      e.id_ok = (e.rid == EID);
      e.ts_ok = TS_EN ? (e.rts == ETS) : 1'b1;
    end else begin
      c += 1;
      e.to = 1'b1;
    end
    e.cyc = c;
    m_rid = e.rid;
    m_rts = e.rts;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", done, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc - e.c0 + 1, e.cyc);
        chk("busy_at_done", busy, 1);
        chk("id_ok", id_ok, e.id_ok);
        chk("ts_ok", ts_ok, e.ts_ok);
        chk("timeout", timeout, e.to);
        chk("read_id", read_id, e.rid);
        chk("read_ts", read_ts, e.rts);
      end
    end
  end

  task automatic run(int si, int st, logic [31:0] vi, logic [31:0] vt,
                     bit mid_start, bit done_start);
    exp_t e;
    int budget;
    sid = si;
    sts = st;
    vid = vi;
    vts = vt;
    e = model(si, st, vi, vt);
    start = 1'b1;
    @(negedge clock);
    e.c0 = cyc;
    q.push_back(e);
    start = 1'b0;
    if (mid_start) begin
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    budget = 0;
    while (q.size() != 0 && budget < 200) begin
      @(negedge clock);
      budget++;
      start = done_start && (done === 1'b1);
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: no done within 200 cycles, expected one");
      q.delete();
    end
    @(negedge clock);
    start = 1'b0;
    chk("idle_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_avm_read"}, avm_read, 0);
    chk({tag, "_avm_address"}, avm_address, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_id_ok"}, id_ok, 0);
    chk({tag, "_ts_ok"}, ts_ok, TS_EN ? 0 : 1);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_read_id"}, read_id, 0);
    chk({tag, "_read_ts"}, read_ts, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    sid = 0;
    sts = 0;
    vid = EID;
    vts = ETS;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    run(0, 0, EID, ETS, 1'b0, 1'b0);
    run(0, 0, EID, 32'h5E44_0000, 1'b0, 1'b0);
    run(3, 3, EID, ETS, 1'b1, 1'b1);
    run(1000, 1000, EID, ETS, 1'b0, 1'b0);
    run(0, 1000, 32'h1234_5678, ETS, 1'b0, 1'b1);
    run(T, T, EID, ETS, 1'b0, 1'b0);
    run(T + 1, 0, EID, ETS, 1'b0, 1'b0);

    // Second start while busy, then reset part-way through the read.
    sid = 1;
    sts = 3;
    vid = 32'hDEAD_BEEF;
    vts = ETS;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    m_rid = '0;
    m_rts = '0;
    @(negedge clock);

    for (int i = 0; i < 24; i++) begin
      int si, st;
      logic [31:0] vi, vt;
      si = $urandom_range(0, 6);
      st = $urandom_range(0, 6);
      vi = ($urandom_range(0, 3) == 0) ? $urandom : EID;
      vt = ($urandom_range(0, 3) == 0) ? $urandom : ETS;
      run(si, st, vi, vt, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
